// File: rtl/ncl_sync_adder_port_pkg.sv
// Shared rail encodings, dual-rail helpers and FSM state types for the
// synchronous boundary around the NCL ripple adder.
package ncl_pkg;

    localparam logic [1:0] NCL_NULL = 2'b00;
    localparam logic [1:0] NCL_D0   = 2'b01;
    localparam logic [1:0] NCL_D1   = 2'b10;

    typedef enum logic [1:0] {
        L_IDLE,
        L_DATA,
        L_NULL
    } launch_t;

    typedef enum logic [1:0] {
        C_WAIT_DATA,
        C_HOLD,
        C_WAIT_NULL
    } capture_t;

    function automatic logic [1:0] ncl_enc(input logic b);
        return b ? NCL_D1 : NCL_D0;
    endfunction

    // Only a clean DATA1 pair decodes to 1; callers check legality separately.
    function automatic logic ncl_dec(input logic [1:0] r);
        return (r == NCL_D1);
    endfunction

endpackage

// File: rtl/ncl_sync_adder_port_if.sv
// Bus between the synchronous world, the port and the NCL adder rails.
// The port takes the slave view; the environment (SoC side plus adder) takes master.
interface ncl_sync_adder_port_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 in_cin;
    logic [2*WIDTH-1:0]   ncl_a;
    logic [2*WIDTH-1:0]   ncl_b;
    logic [1:0]           ncl_cin;
    logic                 ncl_acomp;
    logic [2*WIDTH-1:0]   ncl_sum;
    logic [1:0]           ncl_cout;
    logic                 ncl_sumcomp;
    logic                 ncl_coutcomp;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_sum;
    logic                 out_cout;
    logic                 err_timeout;
    logic                 err_illegal;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, ncl_acomp, ncl_sum, ncl_cout, out_ready,
        output in_ready, ncl_a, ncl_b, ncl_cin, ncl_sumcomp, ncl_coutcomp,
               out_valid, out_sum, out_cout, err_timeout, err_illegal
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, ncl_acomp, ncl_sum, ncl_cout, out_ready,
        input  in_ready, ncl_a, ncl_b, ncl_cin, ncl_sumcomp, ncl_coutcomp,
               out_valid, out_sum, out_cout, err_timeout, err_illegal
    );

endinterface

// File: rtl/ncl_sync_adder_port_sync.sv
// Single-bit multi-flop synchronizer for signals arriving from the
// asynchronous NCL domain; clears to 0 under init_n.
module ncl_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic init_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/ncl_sync_adder_port.sv
// Clocked launch/capture stage around a dual-rail NCL ripple adder: launches
// DATA/NULL wavefronts paced by ACOMP and captures completed sums with sumCOMP.
module ncl_sync_adder_port
    import ncl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic                 clk,
    input  logic                 init_n,
    ncl_sync_adder_port_if.slave bus
);

    localparam int            TW     = $clog2(TIMEOUT + 2);
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    launch_t            lstate, lnext;
    capture_t           cstate, cnext;
    logic               acomp_s, ready_en;
    logic               cmp_data, cmp_data_s, cmp_null, cmp_null_s;
    logic               rail_bad, rail_bad_s;
    logic               in_ready_c, accept;
    logic               cap_load, cap_ack, cap_done;
    logic [1:0]         pair;
    logic [2*WIDTH-1:0] a_enc, b_enc, a_q, b_q;
    logic [1:0]         cin_q;
    logic [WIDTH-1:0]   sum_dec, out_sum_q;
    logic               out_cout_q, out_valid_q, comp_q;
    logic [TW-1:0]      tcnt;
    logic               err_to_q, err_ill_q;

    ncl_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_acomp (
        .clk(clk), .init_n(init_n), .d(bus.ncl_acomp), .q(acomp_s)
    );
    ncl_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
        .clk(clk), .init_n(init_n), .d(cmp_data), .q(cmp_data_s)
    );
    ncl_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_null (
        .clk(clk), .init_n(init_n), .d(cmp_null), .q(cmp_null_s)
    );
    ncl_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bad (
        .clk(clk), .init_n(init_n), .d(rail_bad), .q(rail_bad_s)
    );
    // Holds off in_ready until the ACOMP synchronizer has flushed after reset.
    ncl_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ready (
        .clk(clk), .init_n(init_n), .d(1'b1), .q(ready_en)
    );

    always_comb begin
        cmp_data = (bus.ncl_cout == NCL_D0) || (bus.ncl_cout == NCL_D1);
        cmp_null = (bus.ncl_cout == NCL_NULL);
        rail_bad = (bus.ncl_cout == 2'b11);
        sum_dec  = '0;
        pair     = NCL_NULL;
        for (int i = 0; i < WIDTH; i++) begin
            pair       = bus.ncl_sum[2*i +: 2];
            cmp_data   = cmp_data & ((pair == NCL_D0) || (pair == NCL_D1));
            cmp_null   = cmp_null & (pair == NCL_NULL);
            rail_bad   = rail_bad | (pair == 2'b11);
            sum_dec[i] = ncl_dec(pair);
        end
    end

    always_comb begin
        a_enc = '0;
        b_enc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            a_enc[2*i +: 2] = ncl_enc(bus.in_a[i]);
            b_enc[2*i +: 2] = ncl_enc(bus.in_b[i]);
        end
    end

    assign in_ready_c = ready_en && (lstate == L_IDLE) && !acomp_s;

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            lstate <= L_IDLE;
        end else begin
            lstate <= lnext;
        end
    end

    always_comb begin
        lnext  = lstate;
        accept = 1'b0;
        case (lstate)
            L_IDLE: begin
                if (bus.in_valid && in_ready_c) begin
                    accept = 1'b1;
                    lnext  = L_DATA;
                end
            end
            L_DATA:  if (acomp_s)  lnext = L_NULL;
            L_NULL:  if (!acomp_s) lnext = L_IDLE;
            default: lnext = L_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= NCL_NULL;
        end else if (accept) begin
            a_q   <= a_enc;
            b_q   <= b_enc;
            cin_q <= ncl_enc(bus.in_cin);
        end else if (lstate == L_DATA && lnext == L_NULL) begin
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= NCL_NULL;
        end
    end

    // Any stay in L_DATA/L_NULL is a wait on ACOMP; the count saturates at TIMEOUT.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            tcnt     <= '0;
            err_to_q <= 1'b0;
        end else if (lnext != lstate) begin
            tcnt <= '0;
        end else if (TIMEOUT != 0 && lstate != L_IDLE && tcnt != T_MAX) begin
            tcnt <= tcnt + TW'(1);
            if (tcnt == T_LAST) begin
                err_to_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            cstate <= C_WAIT_DATA;
        end else begin
            cstate <= cnext;
        end
    end

    always_comb begin
        cnext    = cstate;
        cap_load = 1'b0;
        cap_ack  = 1'b0;
        cap_done = 1'b0;
        case (cstate)
            C_WAIT_DATA: begin
                if (cmp_data_s) begin
                    cap_load = 1'b1;
                    cnext    = C_HOLD;
                end
            end
            C_HOLD: begin
                if (bus.out_ready) begin
                    cap_ack = 1'b1;
                    cnext   = C_WAIT_NULL;
                end
            end
            C_WAIT_NULL: begin
                if (cmp_null_s) begin
                    cap_done = 1'b1;
                    cnext    = C_WAIT_DATA;
                end
            end
            default: cnext = C_WAIT_DATA;
        endcase
    end

    // Rails are stable once completion is synchronized, so decoding them here is safe.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            out_valid_q <= 1'b0;
            comp_q      <= 1'b0;
            err_ill_q   <= 1'b0;
        end else begin
            if (cap_load) begin
                out_sum_q   <= sum_dec;
                out_cout_q  <= ncl_dec(bus.ncl_cout);
                out_valid_q <= 1'b1;
            end
            if (cap_ack) begin
                out_valid_q <= 1'b0;
                comp_q      <= 1'b1;
            end
            if (cap_done) begin
                comp_q <= 1'b0;
            end
            if (rail_bad_s) begin
                err_ill_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready     = in_ready_c;
    assign bus.ncl_a        = a_q;
    assign bus.ncl_b        = b_q;
    assign bus.ncl_cin      = cin_q;
    assign bus.ncl_sumcomp  = comp_q;
    assign bus.ncl_coutcomp = comp_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_sum      = out_sum_q;
    assign bus.out_cout     = out_cout_q;
    assign bus.err_timeout  = err_to_q;
    assign bus.err_illegal  = err_ill_q;

endmodule
